seq_stage_controller: RTL and testbench
=======================================

Name: seq_stage_controller

Overview:
- Sequencing controller for the Y86-64 SEQ processor.
- Owns the program counter and steps the fetch, decode, execute, memory and writeback stages one at a time, issuing one enable strobe per stage.
- Computes the next PC from the fetched instruction class, the condition flag and the stage results.
- Classifies termination status (AOK/HLT/ADR/INS) and freezes the machine on halt or fault.

Parameters:
- RESET_PC, 64'd0, PC value loaded at reset.
- MAX_CYCLES, 32'd0, watchdog limit on cycle_count; 0 disables the watchdog.

Ports:
- clock  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  level; leaves IDLE when high.
- in_code  in  4  icode from fetch.
- cnd  in  1  branch condition from execute.
- val_c  in  64  constant word from fetch.
- val_p  in  64  incremented PC from fetch.
- val_m  in  64  memory read data (return address for ret).
- flag_halt  in  1  halt decoded by fetch.
- bad_mem  in  1  instruction address out of range.
- in_error  in  1  invalid icode.
- dmem_error  in  1  data memory address error.
- p_ctr  out  64  current PC, drives fetch.
- en_fetch, en_decode, en_execute, en_memory, en_writeback  out  1 each  one-cycle stage strobes.
- stat  out  2  00 AOK, 01 HLT, 10 ADR, 11 INS.
- busy  out  1  high in every state except IDLE and DONE.
- cycle_count  out  32  cycles spent outside IDLE.
- instr_count  out  32  retired instructions.

Behaviour:
- Reset values: p_ctr=RESET_PC; all enables=0; stat=AOK; busy=0; both counters=0; state=IDLE.
- States and transitions: IDLE -> FETCH -> DECODE -> EXECUTE -> MEMORY -> WRITEBACK -> PC_UPDATE -> FETCH. DONE is terminal.
- IDLE leaves for FETCH only when start=1.
- Strobes: exactly one en_* is high per cycle, and only in its matching state. PC_UPDATE, IDLE and DONE drive all strobes 0.
- Fetch outputs are sampled in DECODE, one cycle after the en_fetch cycle. Fault priority in DECODE:
  - bad_mem: stat=ADR, go to DONE.
  - else in_error: stat=INS, go to DONE.
  - else flag_halt: stat=HLT, go to DONE.
  - Any of these retires the instruction (instr_count+1) and suppresses all later strobes for it.
- dmem_error is sampled in WRITEBACK. If set: stat=ADR, go to DONE, instr_count+1, p_ctr unchanged.
- PC_UPDATE next PC:
  - icode 8 (call): val_c.
  - icode 7 (jXX) with cnd=1: val_c.
  - icode 7 with cnd=0: val_p.
  - icode 9 (ret): val_m.
  - otherwise: val_p.
  - instr_count increments in the same cycle.
- Width rules: PC selection is 64-bit with no arithmetic (val_p already holds the increment). Both counters saturate at 32'hFFFFFFFF.
- cycle_count increments every cycle the state is not IDLE or DONE.
- Watchdog: when MAX_CYCLES!=0 and cycle_count==MAX_CYCLES-1 in any busy state, stat=ADR and go to DONE on the next edge.
- DONE holds p_ctr, stat and counters until reset. start is ignored in DONE.
- Reset mid-operation, in any state, returns to IDLE with reset values on the next edge. No strobe is issued in that cycle.
- start deasserting after leaving IDLE has no effect.
- Simultaneous bad_mem and in_error: ADR wins. in_error together with flag_halt: INS wins.

Decomposition:
- Shared package seq_pkg holds:
  - icode constants: HALT=0, NOP=1, CMOV=2, IRMOV=3, RMMOV=4, MRMOV=5, OPQ=6, JXX=7, CALL=8, RET=9, PUSH=10, POP=11.
  - stat encodings: AOK, HLT, ADR, INS.
  - state enumeration.
- One natural sub-module: seq_next_pc, combinational PC select from icode, cnd, val_c, val_m, val_p.
- FSM, counters and watchdog stay in the top block.

Test Plan:
- Reset, start=1, icode=1, val_p=1: strobes fire in order over cycles 1-5; p_ctr=1 after PC_UPDATE; instr_count=1; cycle_count=6 at the next FETCH.
- icode=7, cnd=0, val_c=0x40, val_p=9: p_ctr=9. Same instruction with cnd=1: p_ctr=0x40.
- icode=8, val_c=0x100 -> p_ctr=0x100. Then icode=9, val_m=0x0A -> p_ctr=0x0A.
- flag_halt=1 in DECODE: stat=01, busy=0, no en_execute; p_ctr frozen; start toggling has no effect.
- bad_mem=1 and in_error=1 together: stat=10. in_error alone: stat=11. dmem_error in WRITEBACK: stat=10 with p_ctr unchanged.
- MAX_CYCLES=10 with an endless nop stream: DONE with stat=10 at cycle_count=10. Reset asserted during EXECUTE: IDLE with all outputs at reset values next cycle.

Source files
------------

// File: rtl/seq_pkg.sv
// seq_pkg: shared icode constants, status codes, FSM states and helpers for the SEQ controller.
//   Contents: icode localparams (HALT..POP), stat_t (AOK/HLT/ADR/INS),
//   state_t (IDLE..DONE), sat_inc (saturating 32-bit increment).
package seq_pkg;
    localparam logic [3:0] HALT = 4'h0, NOP = 4'h1, CMOV = 4'h2, IRMOV = 4'h3,
                           RMMOV = 4'h4, MRMOV = 4'h5, OPQ = 4'h6, JXX = 4'h7,
                           CALL = 4'h8, RET = 4'h9, PUSH = 4'hA, POP = 4'hB;
    typedef enum logic [1:0] {AOK = 2'b00, HLT = 2'b01, ADR = 2'b10, INS = 2'b11} stat_t;
    typedef enum logic [2:0] {
        IDLE, FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, PC_UPDATE, DONE
    } state_t;
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (&v) ? v : v + 32'd1;
    endfunction
endpackage

// File: rtl/seq_next_pc.sv
// seq_next_pc: combinational next-PC select from the fetched icode and stage results.
//   Ports: icode (4), cnd (1), val_c/val_m/val_p (64) in; next_pc (64) out.
module seq_next_pc
    import seq_pkg::*;
(
    input  logic [3:0]  icode,
    input  logic        cnd,
    input  logic [63:0] val_c,
    input  logic [63:0] val_m,
    input  logic [63:0] val_p,
    output logic [63:0] next_pc
);
    assign next_pc = (icode == CALL || (icode == JXX && cnd)) ? val_c :
                     (icode == RET) ? val_m : val_p;
endmodule

// File: rtl/seq_stage_controller.sv
// seq_stage_controller: Y86-64 SEQ sequencer stepping one stage per cycle and owning the PC.
//   Ports: clock, reset (sync, active-high), start (level);
//   in_code, cnd, val_c, val_p, val_m, flag_halt, bad_mem, in_error, dmem_error from the stages;
//   p_ctr, en_fetch..en_writeback strobes, stat, busy, cycle_count, instr_count out.
module seq_stage_controller
    import seq_pkg::*;
#(
    parameter logic [63:0] RESET_PC   = 64'd0,
    parameter logic [31:0] MAX_CYCLES = 32'd0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  in_code,
    input  logic        cnd,
    input  logic [63:0] val_c,
    input  logic [63:0] val_p,
    input  logic [63:0] val_m,
    input  logic        flag_halt,
    input  logic        bad_mem,
    input  logic        in_error,
    input  logic        dmem_error,
    output logic [63:0] p_ctr,
    output logic        en_fetch,
    output logic        en_decode,
    output logic        en_execute,
    output logic        en_memory,
    output logic        en_writeback,
    output logic [1:0]  stat,
    output logic        busy,
    output logic [31:0] cycle_count,
    output logic [31:0] instr_count
);
    state_t      state, state_n;
    logic [63:0] pc_n, next_pc;
    logic [1:0]  stat_n;
    logic [31:0] cc_n, ic_n;
    logic        fault, watchdog;

    seq_next_pc u_next_pc (
        .icode(in_code), .cnd(cnd), .val_c(val_c), .val_m(val_m), .val_p(val_p), .next_pc(next_pc)
    );

    assign busy = state != IDLE && state != DONE;
    // Strobes are gated by reset so the cycle in which reset is sampled issues none.
    assign en_fetch     = !reset && state == FETCH;
    assign en_decode    = !reset && state == DECODE;
    assign en_execute   = !reset && state == EXECUTE;
    assign en_memory    = !reset && state == MEMORY;
    assign en_writeback = !reset && state == WRITEBACK;
    assign fault    = bad_mem || in_error || flag_halt;
    assign watchdog = MAX_CYCLES != 32'd0 && busy && cycle_count == MAX_CYCLES - 32'd1;

    always_comb begin
        state_n = state;
        pc_n    = p_ctr;
        stat_n  = stat;
        cc_n    = busy ? sat_inc(cycle_count) : cycle_count;
        ic_n    = instr_count;
        case (state)
            IDLE:      state_n = start ? FETCH : IDLE;
            FETCH:     state_n = DECODE;
            DECODE: begin
                state_n = fault ? DONE : EXECUTE;
                stat_n  = bad_mem ? ADR : in_error ? INS : flag_halt ? HLT : stat;
                ic_n    = fault ? sat_inc(instr_count) : instr_count;
            end
            EXECUTE:   state_n = MEMORY;
            MEMORY:    state_n = WRITEBACK;
            WRITEBACK: begin
                state_n = dmem_error ? DONE : PC_UPDATE;
                stat_n  = dmem_error ? ADR : stat;
                ic_n    = dmem_error ? sat_inc(instr_count) : instr_count;
            end
            PC_UPDATE: begin
                state_n = FETCH;
                pc_n    = next_pc;
                ic_n    = sat_inc(instr_count);
            end
            default:   state_n = DONE;
        endcase
        // The watchdog overrides whatever the current stage would have done.
        if (watchdog) begin
            state_n = DONE;
            stat_n  = ADR;
            pc_n    = p_ctr;
            ic_n    = instr_count;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            p_ctr       <= RESET_PC;
            stat        <= AOK;
            cycle_count <= '0;
            instr_count <= '0;
        end else begin
            state       <= state_n;
            p_ctr       <= pc_n;
            stat        <= stat_n;
            cycle_count <= cc_n;
            instr_count <= ic_n;
        end
    end
endmodule

// File: tb/tb_seq_stage_controller.sv
// tb_seq_stage_controller: self-checking bench for seq_stage_controller.
module tb_seq_stage_controller;
    logic        clock = 1'b0, reset, start, start_w;
    logic [3:0]  in_code;
    logic        cnd, flag_halt, bad_mem, in_error, dmem_error;
    logic [63:0] val_c, val_p, val_m, p_ctr, p_w;
    logic        en_fetch, en_decode, en_execute, en_memory, en_writeback, busy;
    logic        ef_w, ed_w, ee_w, em_w, ew_w, busy_w;
    logic [1:0]  stat, stat_w;
    logic [31:0] cycle_count, instr_count, cc_w, ic_w;
    logic [4:0]  strobes;
    int          checks = 0, errors = 0;
    logic [63:0] exp_q[$];
    logic [63:0] exp_pc;

    typedef struct {
        logic [3:0]  icode;
        logic        c;
        logic [63:0] vc, vp, vm, pc;
    } vec_t;
    vec_t vecs[7];

    always #5 clock = ~clock;
    assign strobes = {en_fetch, en_decode, en_execute, en_memory, en_writeback};

    seq_stage_controller dut (
        .clock(clock), .reset(reset), .start(start), .in_code(in_code), .cnd(cnd),
        .val_c(val_c), .val_p(val_p), .val_m(val_m), .flag_halt(flag_halt), .bad_mem(bad_mem),
        .in_error(in_error), .dmem_error(dmem_error), .p_ctr(p_ctr), .en_fetch(en_fetch),
        .en_decode(en_decode), .en_execute(en_execute), .en_memory(en_memory),
        .en_writeback(en_writeback), .stat(stat), .busy(busy), .cycle_count(cycle_count),
        .instr_count(instr_count)
    );

    seq_stage_controller #(.MAX_CYCLES(32'd10)) dut_w (
        .clock(clock), .reset(reset), .start(start_w), .in_code(4'd1), .cnd(1'b0),
        .val_c(64'd0), .val_p(64'd8), .val_m(64'd0), .flag_halt(1'b0), .bad_mem(1'b0),
        .in_error(1'b0), .dmem_error(1'b0), .p_ctr(p_w), .en_fetch(ef_w),
        .en_decode(ed_w), .en_execute(ee_w), .en_memory(em_w),
        .en_writeback(ew_w), .stat(stat_w), .busy(busy_w), .cycle_count(cc_w),
        .instr_count(ic_w)
    );

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Drives one instruction starting in FETCH and leaves the DUT in the next FETCH.
    task automatic do_instr(input logic [3:0] ic, input logic c, input logic [63:0] vc,
                            input logic [63:0] vp, input logic [63:0] vm);
        in_code = ic; cnd = c; val_c = vc; val_p = vp; val_m = vm;
        chk("strobe_fetch", strobes, 5'b10000);
        tick; chk("strobe_decode", strobes, 5'b01000);
        tick; chk("strobe_execute", strobes, 5'b00100);
        tick; chk("strobe_memory", strobes, 5'b00010);
        tick; chk("strobe_writeback", strobes, 5'b00001);
        tick; chk("strobe_pc_update", strobes, 5'b00000);
        chk("busy_pc_update", busy, 1);
        tick;
    endtask

    task automatic restart;
        reset = 1; start = 0;
        flag_halt = 0; bad_mem = 0; in_error = 0; dmem_error = 0;
        tick;
        reset = 0; start = 1;
        tick;
        start = 0;
    endtask

    initial begin
        vecs[0] = '{4'd1,  1'b0, 64'h0,   64'h1,  64'h0,  64'h1};
        vecs[1] = '{4'd7,  1'b0, 64'h40,  64'h9,  64'h0,  64'h9};
        vecs[2] = '{4'd7,  1'b1, 64'h40,  64'h9,  64'h0,  64'h40};
        vecs[3] = '{4'd8,  1'b0, 64'h100, 64'h20, 64'h0,  64'h100};
        vecs[4] = '{4'd9,  1'b0, 64'h0,   64'h30, 64'hA,  64'hA};
        vecs[5] = '{4'd6,  1'b1, 64'h55,  64'h77, 64'h0,  64'h77};
        vecs[6] = '{4'd11, 1'b0, 64'h0,   64'h12, 64'h99, 64'h12};
        reset = 1; start = 0; start_w = 0; in_code = 0; cnd = 0;
        val_c = 0; val_p = 0; val_m = 0;
        flag_halt = 0; bad_mem = 0; in_error = 0; dmem_error = 0;
        tick; tick;
        chk("rst_pc", p_ctr, 0);
        chk("rst_strobes", strobes, 0);
        chk("rst_stat", stat, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cc", cycle_count, 0);
        chk("rst_ic", instr_count, 0);
        reset = 0;
        tick; tick;
        chk("idle_busy", busy, 0);
        chk("idle_cc", cycle_count, 0);
        chk("idle_strobes", strobes, 0);
        start = 1;
        tick;
        start = 0;
        for (int i = 0; i < 7; i++) begin
            exp_q.push_back(vecs[i].pc);
            do_instr(vecs[i].icode, vecs[i].c, vecs[i].vc, vecs[i].vp, vecs[i].vm);
            exp_pc = exp_q.pop_front();
            chk($sformatf("pc_%0d", i), p_ctr, exp_pc);
            chk($sformatf("cc_%0d", i), cycle_count, 64'(6 * (i + 1)));
            chk($sformatf("ic_%0d", i), instr_count, 64'(i + 1));
        end
        // Halt decoded: freeze with HLT, no execute strobe, start ignored.
        in_code = 4'd0; flag_halt = 1;
        tick; chk("halt_decode", strobes, 5'b01000);
        tick;
        chk("halt_stat", stat, 2'b01);
        chk("halt_busy", busy, 0);
        chk("halt_strobes", strobes, 0);
        chk("halt_pc", p_ctr, 64'h12);
        chk("halt_ic", instr_count, 8);
        chk("halt_cc", cycle_count, 44);
        for (int i = 0; i < 4; i++) begin
            start = ~start;
            tick;
            chk("done_strobes", strobes, 0);
            chk("done_pc", p_ctr, 64'h12);
            chk("done_stat", stat, 2'b01);
            chk("done_cc", cycle_count, 44);
        end
        restart; bad_mem = 1; in_error = 1;
        tick; tick;
        chk("adr_ins_stat", stat, 2'b10);
        chk("adr_ins_pc", p_ctr, 0);
        chk("adr_ins_ic", instr_count, 1);
        chk("adr_ins_busy", busy, 0);
        restart; in_error = 1; flag_halt = 1;
        tick; tick;
        chk("ins_hlt_stat", stat, 2'b11);
        restart; in_error = 1;
        tick; tick;
        chk("ins_stat", stat, 2'b11);
        chk("ins_strobes", strobes, 0);
        // Data memory fault after one good instruction: PC keeps the first result.
        restart;
        do_instr(4'd1, 1'b0, 64'h0, 64'h5, 64'h0);
        dmem_error = 1; val_p = 64'h9;
        tick; chk("dmem_decode_stat", stat, 0);
        tick; tick; tick;
        chk("dmem_wb_strobe", strobes, 5'b00001);
        tick;
        chk("dmem_stat", stat, 2'b10);
        chk("dmem_pc", p_ctr, 64'h5);
        chk("dmem_ic", instr_count, 2);
        chk("dmem_busy", busy, 0);
        tick; chk("dmem_strobes", strobes, 0);
        // Reset during EXECUTE.
        restart;
        do_instr(4'd1, 1'b0, 64'h0, 64'h33, 64'h0);
        tick; tick;
        chk("mid_exec_strobe", strobes, 5'b00100);
        reset = 1;
        #1 chk("mid_rst_strobes", strobes, 0);
        tick;
        chk("mid_rst_pc", p_ctr, 0);
        chk("mid_rst_stat", stat, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_cc", cycle_count, 0);
        chk("mid_rst_ic", instr_count, 0);
        chk("mid_rst_strobes2", strobes, 0);
        reset = 0;
        // Watchdog instance: endless nop stream stops at cycle_count 10.
        tick;
        start_w = 1;
        tick;
        for (int n = 0; n < 40; n++) begin
            if (!busy_w) break;
            tick;
        end
        chk("wd_done", busy_w, 0);
        chk("wd_stat", stat_w, 2'b10);
        chk("wd_cc", cc_w, 10);
        chk("wd_ic", ic_w, 1);
        chk("wd_pc", p_w, 64'h8);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
